// File: rtl/lsu_pkg.sv
// lsu_pkg: shared access-type and state encodings for the handshaked load/store unit
package lsu_pkg;
    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b011,
        LSU_HU = 3'b100
    } lsu_type_e;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } lsu_state_e;
    localparam int XLEN_C = 32;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane placement, load extraction and misalign flag (trap via LSU_MISALIGN_TRAP_EN)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  typ,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_pl,
    output logic [31:0] rdata_ex,
    output logic        misalign
);
    logic        half;
    logic        word;
    logic [1:0]  eoff;
    logic [31:0] sh;
    always_comb begin
        half = typ == LSU_H || typ == LSU_HU;
        word = typ == LSU_W;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (half && off[0]) || (word && off != 2'b00);
        eoff     = off;
`else
        // Without the trap, accesses are silently aligned down to their natural size.
        misalign = 1'b0;
        eoff     = word ? 2'b00 : half ? {off[1], 1'b0} : off;
`endif
        be       = word ? 4'b1111 : half ? 4'b0011 << eoff : 4'b0001 << eoff;
        wdata_pl = word ? wdata : half ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        sh       = rdata >> {eoff, 3'b000};
        rdata_ex = typ == LSU_B  ? {{24{sh[7]}}, sh[7:0]} :
                   typ == LSU_BU ? {24'h0, sh[7:0]} :
                   typ == LSU_H  ? {{16{sh[15]}}, sh[15:0]} :
                   typ == LSU_HU ? {16'h0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/lsu_hs.sv
// lsu_hs: multi-cycle load/store unit with req/ack memory handshake and timeout (misalign trap via LSU_MISALIGN_TRAP_EN)
module lsu_hs
    import lsu_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int WAIT_MAX = 16,
    parameter int XLEN     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_type_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);
    if (XLEN != XLEN_C) begin : g_bad_xlen
        $error("lsu_hs: XLEN must be 32");
    end
    localparam int CW = $clog2(WAIT_MAX + 1) + 1;
    lsu_state_e        state;
    logic [CW-1:0]     cnt;
    logic              we_q;
    logic              err_q;
    logic [2:0]        typ_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [3:0]        be;
    logic [31:0]       wdata_pl;
    logic [31:0]       rdata_ex;
    logic              misalign;
    logic              idle;
    logic              fault;
    logic              timeout;
    logic              unused_addr;
    assign unused_addr = ^req_addr_i[31:ADDR_W];
    assign idle        = state == ST_IDLE;
    assign fault       = misalign || (req_we_i ? req_type_i > LSU_W : req_type_i > LSU_HU);
    assign timeout     = WAIT_MAX != 0 && cnt == CW'(WAIT_MAX - 1);
    // Decode operates on the live request in IDLE and on the captured access afterwards.
    lsu_align u_align (
        .typ      (idle ? req_type_i : typ_q),
        .off      (idle ? req_addr_i[1:0] : off_q),
        .wdata    (req_wdata_i),
        .rdata    (mem_rdata_i),
        .be       (be),
        .wdata_pl (wdata_pl),
        .rdata_ex (rdata_ex),
        .misalign (misalign)
    );
    assign req_ready_o  = idle;
    assign resp_valid_o = state == ST_DONE;
    assign resp_err_o   = err_q;
    assign resp_rdata_o = rdata_q;
    assign mem_req_o    = state == ST_REQ;
    assign mem_we_o     = mem_req_o && we_q;
    assign mem_addr_o   = mem_req_o ? addr_q : '0;
    assign mem_be_o     = mem_req_o ? be_q : '0;
    assign mem_wdata_o  = mem_req_o ? wdata_q : '0;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            typ_q   <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid_i) begin
                    we_q    <= req_we_i;
                    typ_q   <= req_type_i;
                    off_q   <= req_addr_i[1:0];
                    addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                    be_q    <= be;
                    wdata_q <= req_we_i ? wdata_pl : '0;
                    err_q   <= fault;
                    rdata_q <= '0;
                    cnt     <= '0;
                    state   <= fault ? ST_DONE : ST_REQ;
                end
                ST_REQ: if (mem_ack_i) begin
                    rdata_q <= we_q ? '0 : rdata_ex;
                    state   <= ST_DONE;
                end else if (timeout) begin
                    err_q <= 1'b1;
                    state <= ST_DONE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_hs.sv
// tb_lsu_hs: randomized and directed checks of lsu_hs against a byte-level reference model
module tb_lsu_hs;
    localparam int WAIT = 4;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_type_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [11:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    int          n_tests = 0;
    int          n_fail = 0;
    lsu_hs #(.ADDR_W(12), .WAIT_MAX(WAIT), .XLEN(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_type_i   (req_type_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_err_o   (resp_err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic int size_of(input logic [2:0] t);
        return (t == 3'd0 || t == 3'd3) ? 1 : (t == 3'd1 || t == 3'd4) ? 2 : 4;
    endfunction
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask
    // Full transaction: drive request, act as memory with ack after dly REQ cycles, check everything.
    task automatic txn(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] word, input int dly);
        int          n;
        int          off;
        int          eo;
        bit          fault;
        logic [3:0]  xbe;
        logic [31:0] xwd;
        logic [31:0] xrd;
        n     = size_of(t);
        off   = int'(a[1:0]);
        eo    = off - (off % n);
        fault = we ? (t > 3'd2) : (t > 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % n != 0) fault = 1'b1;
`endif
        xbe = '0;
        xrd = '0;
        xwd = '0;
        for (int i = 0; i < n; i++) begin
            xbe[eo+i] = 1'b1;
            xrd[8*i +: 8] = word[8*(eo+i) +: 8];
        end
        if ((t == 3'd0 || t == 3'd1) && xrd[8*n-1]) xrd = xrd | (32'hffffffff << (8*n));
        for (int j = 0; j < 4; j++) xwd[8*j +: 8] = wd[8*(j % n) +: 8];
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_type_i  = t;
        req_addr_i  = a;
        req_wdata_i = wd;
        check("ready_idle", {31'h0, req_ready_o}, 32'h1);
        cycle();
        req_valid_i = 1'b0;
        if (fault) begin
            check("fault_valid", {31'h0, resp_valid_o}, 32'h1);
            check("fault_err", {31'h0, resp_err_o}, 32'h1);
            check("fault_memreq", {31'h0, mem_req_o}, 32'h0);
            check("fault_rdata", resp_rdata_o, 32'h0);
        end else begin
            for (int k = 0; k < WAIT; k++) begin
                check("mem_req", {31'h0, mem_req_o}, 32'h1);
                check("mem_we", {31'h0, mem_we_o}, {31'h0, we});
                check("mem_addr", {20'h0, mem_addr_o}, {20'h0, a[11:2], 2'b00});
                check("mem_be", {28'h0, mem_be_o}, {28'h0, xbe});
                check("mem_wdata", mem_wdata_o, we ? xwd : 32'h0);
                check("busy_ready", {31'h0, req_ready_o}, 32'h0);
                check("busy_valid", {31'h0, resp_valid_o}, 32'h0);
                mem_ack_i   = (k == dly);
                mem_rdata_i = (k == dly) ? word : $urandom;
                cycle();
                mem_ack_i = 1'b0;
                if (k == dly) break;
            end
            check("resp_valid", {31'h0, resp_valid_o}, 32'h1);
            check("resp_err", {31'h0, resp_err_o}, {31'h0, dly >= WAIT});
            check("resp_rdata", resp_rdata_o, (dly >= WAIT || we) ? 32'h0 : xrd);
            check("resp_memreq", {31'h0, mem_req_o}, 32'h0);
        end
        cycle();
        check("after_valid", {31'h0, resp_valid_o}, 32'h0);
        check("after_ready", {31'h0, req_ready_o}, 32'h1);
    endtask
    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_type_i  = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        @(negedge clk);
        cycle();
        rst_i = 1'b0;
        check("rst_ready", {31'h0, req_ready_o}, 32'h1);
        check("rst_valid", {31'h0, resp_valid_o}, 32'h0);
        check("rst_memreq", {31'h0, mem_req_o}, 32'h0);
        check("rst_be", {28'h0, mem_be_o}, 32'h0);
        check("rst_rdata", resp_rdata_o, 32'h0);
        check("rst_err", {31'h0, resp_err_o}, 32'h0);
        txn(1'b0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 2);
        txn(1'b1, 3'd1, 32'h0000_002A, 32'h0000_BEEF, 32'h0, 0);
        txn(1'b0, 3'd2, 32'h0000_0005, 32'h0, 32'hCAFE_F00D, 1);
        txn(1'b0, 3'd4, 32'hFFFF_F003, 32'h0, 32'h8001_7FFF, 0);
        txn(1'b0, 3'd2, 32'h0000_0040, 32'h0, 32'h1111_1111, 9);
        txn(1'b0, 3'd2, 32'h0000_0044, 32'h0, 32'h2222_2222, 3);
        txn(1'b1, 3'd3, 32'h0000_0010, 32'h1234_5678, 32'h0, 0);
        txn(1'b0, 3'd5, 32'h0000_0010, 32'h0, 32'h0, 0);
        for (int r = 0; r < 150; r++)
            txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_type_i  = 3'd2;
        req_addr_i  = 32'h0000_0010;
        cycle();
        req_valid_i = 1'b0;
        check("pre_rst_memreq", {31'h0, mem_req_o}, 32'h1);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        check("abort_memreq", {31'h0, mem_req_o}, 32'h0);
        check("abort_ready", {31'h0, req_ready_o}, 32'h1);
        check("abort_valid", {31'h0, resp_valid_o}, 32'h0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("stray_ack_valid", {31'h0, resp_valid_o}, 32'h0);
            check("stray_ack_memreq", {31'h0, mem_req_o}, 32'h0);
        end
        mem_ack_i = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
